// File: rtl/key_debounce_pkg.sv
// key_pkg: debouncer FSM state encodings and default timing constants,
// shared with the LED shift stage's testbench.
package key_pkg;
   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      PRESS_FILTER   = 2'd1,
      DOWN           = 2'd2,
      RELEASE_FILTER = 2'd3
   } key_state_t;
   localparam int unsigned KEY_CNT_MAX  = 1_000_000;
   localparam int unsigned KEY_LONG_MAX = 50_000_000;
endpackage

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchroniser with parameterised reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         o_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: active-low push-button debouncer with press/release/long strobes.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX  = KEY_CNT_MAX,
   parameter int unsigned LONG_MAX = KEY_LONG_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic key_out,
   output logic key_press,
   output logic key_release,
   output logic key_long
);
`ifdef KEY_LONG_PRESS_EN
   localparam int unsigned CNT_W = $clog2(LONG_MAX + 1);
   localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_MAX - 1);
`else
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
`endif
   localparam logic [CNT_W-1:0] FILT_END = CNT_W'(CNT_MAX - 1);

   if (CNT_MAX < 2 || LONG_MAX <= CNT_MAX) begin : g_param_check
      $error("key_debounce: need CNT_MAX >= 2 and LONG_MAX > CNT_MAX");
   end

   logic             w_key_s;
   key_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_key_out, w_key_out_nxt;
   logic             r_press, w_press_nxt;
   logic             r_release, w_release_nxt;
   logic             r_long, w_long_nxt;
   logic             r_long_done, w_long_done_nxt;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (key),
      .o_q     (w_key_s)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_key_out   <= 1'b1;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_long_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_key_out   <= w_key_out_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
         r_long      <= w_long_nxt;
         r_long_done <= w_long_done_nxt;
      end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_key_out_nxt   = r_key_out;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_long_nxt      = 1'b0;
      w_long_done_nxt = r_long_done;
      case (r_state)
         IDLE:
            if (!w_key_s) begin
               w_state_nxt = PRESS_FILTER;
               w_cnt_nxt   = '0;
            end
         PRESS_FILTER:
            if (w_key_s) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == FILT_END) begin
               w_state_nxt     = DOWN;
               w_cnt_nxt       = '0;
               w_key_out_nxt   = 1'b0;
               w_press_nxt     = 1'b1;
               w_long_done_nxt = 1'b0;
            end else
               w_cnt_nxt = r_cnt + 1'b1;
         DOWN:
            if (w_key_s) begin
               w_state_nxt = RELEASE_FILTER;
               w_cnt_nxt   = '0;
            end
`ifdef KEY_LONG_PRESS_EN
            // cnt parks at LONG_END; the done flag keeps key_long to one strobe
            else if (r_cnt != LONG_END)
               w_cnt_nxt = r_cnt + 1'b1;
            else if (!r_long_done) begin
               w_long_nxt      = 1'b1;
               w_long_done_nxt = 1'b1;
            end
`endif
         RELEASE_FILTER:
            if (!w_key_s) begin
               w_state_nxt     = DOWN;
               w_cnt_nxt       = '0;
               w_long_done_nxt = 1'b0;
            end else if (r_cnt == FILT_END) begin
               w_state_nxt   = IDLE;
               w_cnt_nxt     = '0;
               w_key_out_nxt = 1'b1;
               w_release_nxt = 1'b1;
            end else
               w_cnt_nxt = r_cnt + 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign key_out     = r_key_out;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_long    = r_long;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; stimulus queues expected strobes with their
// cycle and level, a negedge monitor pops and compares each strobe the DUT emits.
module tb_key_debounce;
   import key_pkg::*;

   typedef struct {
      logic [2:0] ev;
      int         cyc;
      logic       lvl;
   } exp_t;

   localparam logic [2:0] EV_PRESS = 3'b001, EV_RELEASE = 3'b010, EV_LONG = 3'b100;

   logic clk = 1'b0, rst_n = 1'b0, key = 1'b1;
   logic key_out, key_press, key_release, key_long;
   int   cyc = 0, checks = 0, failures = 0, t = 0;
   exp_t q[$];
   exp_t e;

   key_debounce #(.CNT_MAX(4), .LONG_MAX(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key),
      .key_out     (key_out),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] ev, input int c, input logic lvl);
      exp_t x;
      x.ev = ev; x.cyc = c; x.lvl = lvl;
      q.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk)
      if (rst_n && (key_press || key_release || key_long)) begin
         if (q.size() == 0)
            chk("unexpected_strobe", int'({key_long, key_release, key_press}), 0);
         else begin
            e = q.pop_front();
            chk("strobe_kind", int'({key_long, key_release, key_press}), int'(e.ev));
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_level", int'(key_out), int'(e.lvl));
         end
      end

   initial begin
      step(3);
      chk("rst_key_out", int'(key_out), 1);
      chk("rst_strobes", int'({key_long, key_release, key_press}), 0);
      chk("rst_state", int'(dut.r_state), int'(IDLE));
      rst_n = 1'b1;
      step(3);
      // clean press held 30 cycles, then clean release
      key = 1'b0; t = cyc;
      push(EV_PRESS, t + 7, 1'b0);
`ifdef KEY_LONG_PRESS_EN
      push(EV_LONG, t + 23, 1'b0);
`endif
      step(6);
      chk("pre_press_level", int'(key_out), 1);
      step(24);
      chk("held_level", int'(key_out), 0);
      key = 1'b1; t = cyc;
      push(EV_RELEASE, t + 7, 1'b1);
      step(12);
      chk("released_level", int'(key_out), 1);
      // bounce never reaches a full window
      key = 1'b0; step(2);
      key = 1'b1; step(1);
      key = 1'b0; step(2);
      key = 1'b1; step(10);
      chk("bounce_level", int'(key_out), 1);
      chk("bounce_state", int'(dut.r_state), int'(IDLE));
      // press, then release with a one-cycle low glitch
      key = 1'b0; t = cyc;
      push(EV_PRESS, t + 7, 1'b0);
      step(12);
      key = 1'b1; step(2);
      key = 1'b0; step(1);
      key = 1'b1; t = cyc;
      push(EV_RELEASE, t + 7, 1'b1);
      step(6);
      chk("glitch_hold_level", int'(key_out), 0);
      step(6);
      chk("glitch_release_level", int'(key_out), 1);
      // reset while in DOWN, key held low through reset
      key = 1'b0; t = cyc;
      push(EV_PRESS, t + 7, 1'b0);
      step(10);
      chk("down_before_reset", int'(dut.r_state), int'(DOWN));
      rst_n = 1'b0;
      #1;
      chk("midrst_key_out", int'(key_out), 1);
      chk("midrst_strobes", int'({key_long, key_release, key_press}), 0);
      chk("midrst_state", int'(dut.r_state), int'(IDLE));
      step(2);
      rst_n = 1'b1; t = cyc;
      push(EV_PRESS, t + 7, 1'b0);
      step(10);
      key = 1'b1; t = cyc;
      push(EV_RELEASE, t + 7, 1'b1);
      step(12);
      chk("final_level", int'(key_out), 1);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
